// File: rtl/ntt_cfg_pkg.sv
// Shared configuration for the streaming NTT pipeline: default sizes, derived
// widths and the index/mask types used by the control plane.
package ntt_cfg_pkg;

    localparam int N          = 1024;
    localparam int P          = 32;
    localparam int BEATS      = N / P;
    localparam int BW         = $clog2(BEATS);
    localparam int NUM_STAGES = 10;
    localparam int STAGE_LAT  = 8;
    localparam int TOT_LAT    = NUM_STAGES * STAGE_LAT;

    // Frames in flight can never exceed TOT_LAT/BEATS + 1, so this width leaves headroom.
    function automatic int frame_width(input int tot_lat, input int beats);
        return $clog2(tot_lat / beats + 3);
    endfunction

    localparam int FW = frame_width(TOT_LAT, BEATS);

    typedef logic [BW-1:0]         beat_idx_t;
    typedef logic [NUM_STAGES-1:0] stage_mask_t;

endpackage

// File: rtl/ntt_stage_sequencer_if.sv
// Control bundle between the frame source and the stage sequencer.
interface ntt_stage_sequencer_if
    import ntt_cfg_pkg::*;
#(
    parameter int NSTG  = NUM_STAGES,
    parameter int IDX_W = BW,
    parameter int CNT_W = FW
);

    logic             in_start;
    logic             clear_err;
    logic [NSTG-1:0]  stage_start;
    logic             out_start;
    logic             in_busy;
    logic [IDX_W-1:0] in_beat_idx;
    logic [IDX_W-1:0] out_beat_idx;
    logic             frame_done;
    logic [CNT_W-1:0] frames_in_flight;
    logic             err_overlap;

    modport master (
        output in_start, clear_err,
        input  stage_start, out_start, in_busy, in_beat_idx, out_beat_idx,
        input  frame_done, frames_in_flight, err_overlap
    );

    modport slave (
        input  in_start, clear_err,
        output stage_start, out_start, in_busy, in_beat_idx, out_beat_idx,
        output frame_done, frames_in_flight, err_overlap
    );

endinterface

// File: rtl/ntt_beat_window.sv
// Frame-long beat window: a start pulse opens a BEATS-cycle window and the
// counter walks 1..BEATS-1 over the cycles that follow it.
module ntt_beat_window #(
    parameter int BEATS = 32,
    parameter int BW    = $clog2(BEATS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic [BW-1:0] beat_idx,
    output logic          last
);

    logic          busy_q, busy_d;
    logic [BW-1:0] idx_q, idx_d;

    always_comb begin
        busy_d = busy_q;
        idx_d  = idx_q;
        if (start) begin
            busy_d = 1'b1;
            idx_d  = BW'(1);
        end else if (busy_q) begin
            if (idx_q == BW'(BEATS - 1)) begin
                busy_d = 1'b0;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            busy_q <= busy_d;
            idx_q  <= idx_d;
        end
    end

    assign busy     = busy_q;
    assign beat_idx = idx_q;
    assign last     = busy_q && (idx_q == BW'(BEATS - 1));

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Stage sequencer: admits frame starts against the ingest window and replays
// each accepted start to every pipeline stage through a fixed delay line.
module ntt_stage_sequencer #(
    parameter int N          = ntt_cfg_pkg::N,
    parameter int P          = ntt_cfg_pkg::P,
    parameter int NUM_STAGES = ntt_cfg_pkg::NUM_STAGES,
    parameter int STAGE_LAT  = ntt_cfg_pkg::STAGE_LAT
) (
    input logic                  clk,
    input logic                  rst,
    ntt_stage_sequencer_if.slave bus
);

    import ntt_cfg_pkg::*;

    localparam int SEQ_BEATS = N / P;
    localparam int SEQ_BW    = $clog2(SEQ_BEATS);
    localparam int SEQ_TOT   = NUM_STAGES * STAGE_LAT;
    localparam int SEQ_FW    = frame_width(SEQ_TOT, SEQ_BEATS);

    logic [SEQ_TOT-1:0] dly_q, dly_d;
    logic [SEQ_FW-1:0]  fif_q, fif_d;
    logic               err_q, err_d;
    logic               accept, reject;
    logic               in_busy, in_last;
    logic               out_start, out_busy;

    ntt_beat_window #(.BEATS(SEQ_BEATS), .BW(SEQ_BW)) u_ingest (
        .clk      (clk),
        .rst      (rst),
        .start    (accept),
        .busy     (in_busy),
        .beat_idx (bus.in_beat_idx),
        .last     (in_last)
    );

    ntt_beat_window #(.BEATS(SEQ_BEATS), .BW(SEQ_BW)) u_egress (
        .clk      (clk),
        .rst      (rst),
        .start    (out_start),
        .busy     (out_busy),
        .beat_idx (bus.out_beat_idx),
        .last     (bus.frame_done)
    );

    assign out_start = dly_q[SEQ_TOT-1];

    always_comb begin
        accept = bus.in_start && !in_busy;
        reject = bus.in_start && in_busy;

        dly_d    = dly_q << 1;
        dly_d[0] = accept;

        fif_d = fif_q;
        case ({accept, out_start})
            2'b10:   fif_d = fif_q + SEQ_FW'(1);
            2'b01:   fif_d = fif_q - SEQ_FW'(1);
            default: fif_d = fif_q;
        endcase

        // A rejection in the same cycle as clear_err must leave the flag set.
        if (reject) begin
            err_d = 1'b1;
        end else if (bus.clear_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q <= '0;
            fif_q <= '0;
            err_q <= 1'b0;
        end else begin
            dly_q <= dly_d;
            fif_q <= fif_d;
            err_q <= err_d;
            assert (!(accept && !out_start && (&fif_q)))
                else $error("frames_in_flight overflow");
            assert (!(out_start && !accept && (fif_q == '0)))
                else $error("frames_in_flight underflow");
            assert (!(out_start && out_busy))
                else $error("egress window restarted while open");
            assert (!(accept && in_last))
                else $error("frame accepted inside ingest window");
        end
    end

    // Stage s sees beat 0 (s+1)*STAGE_LAT cycles after the accepted start.
    always_comb begin
        bus.stage_start = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            bus.stage_start[s] = dly_q[(s + 1) * STAGE_LAT - 1];
        end
    end

    assign bus.out_start        = out_start;
    assign bus.in_busy          = in_busy;
    assign bus.frames_in_flight = fif_q;
    assign bus.err_overlap      = err_q;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: default configuration plus a small
// N=64/P=8/6-stage/latency-1 instance, both checked against a frame-list model.
module tb_ntt_stage_sequencer;

    logic clk = 1'b0;
    logic rst_d = 1'b1;
    logic rst_s = 1'b1;

    always #5 clk = ~clk;

    ntt_stage_sequencer_if #(.NSTG(10), .IDX_W(5), .CNT_W(3)) d_if ();
    ntt_stage_sequencer_if #(.NSTG(6),  .IDX_W(3), .CNT_W(2)) s_if ();

    ntt_stage_sequencer u_dut (
        .clk (clk),
        .rst (rst_d),
        .bus (d_if)
    );

    ntt_stage_sequencer #(.N(64), .P(8), .NUM_STAGES(6), .STAGE_LAT(1)) u_small (
        .clk (clk),
        .rst (rst_s),
        .bus (s_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit sel    = 1'b0;

    // Model state: start cycles of accepted frames since the last reset.
    int acc_q[$];
    int m_beats = 32;
    int m_lat   = 8;
    int m_nst   = 10;
    bit m_err   = 1'b0;

    function automatic logic [63:0] pack(input logic [31:0] stage, input logic [31:0] os,
                                         input logic [31:0] busy,  input logic [31:0] ib,
                                         input logic [31:0] ob,    input logic [31:0] done,
                                         input logic [31:0] fif,   input logic [31:0] err);
        logic [63:0] p;
        p        = '0;
        p[15:0]  = stage[15:0];
        p[16]    = os[0];
        p[17]    = busy[0];
        p[25:18] = ib[7:0];
        p[33:26] = ob[7:0];
        p[34]    = done[0];
        p[38:35] = fif[3:0];
        p[39]    = err[0];
        return p;
    endfunction

    function automatic logic [63:0] obs();
        if (sel)
            return pack(32'(s_if.stage_start), 32'(s_if.out_start), 32'(s_if.in_busy),
                        32'(s_if.in_beat_idx), 32'(s_if.out_beat_idx), 32'(s_if.frame_done),
                        32'(s_if.frames_in_flight), 32'(s_if.err_overlap));
        return pack(32'(d_if.stage_start), 32'(d_if.out_start), 32'(d_if.in_busy),
                    32'(d_if.in_beat_idx), 32'(d_if.out_beat_idx), 32'(d_if.frame_done),
                    32'(d_if.frames_in_flight), 32'(d_if.err_overlap));
    endfunction

    // Expected outputs for cycle c, derived directly from the accepted start times.
    function automatic logic [63:0] model_out(input int c);
        int stage, ib, ob, fif, tot, t, u;
        bit busy, done;
        stage = 0; ib = 0; ob = 0; fif = 0; busy = 0; done = 0;
        tot = m_nst * m_lat;
        foreach (acc_q[i]) begin
            t = acc_q[i];
            u = t + tot;
            for (int s = 0; s < m_nst; s++)
                if (c == t + (s + 1) * m_lat) stage = stage | (1 << s);
            if (c > t && c < t + m_beats) begin busy = 1; ib = c - t; end
            if (c > u && c < u + m_beats) ob = c - u;
            if (c == u + m_beats - 1) done = 1;
            if (t < c && c <= u) fif++;
        end
        return pack(stage, (stage >> (m_nst - 1)) & 1, busy, ib, ob, done, fif, m_err);
    endfunction

    task automatic drive(input bit st, input bit clr, input bit rs);
        logic [63:0] e;
        bit acc;
        if (rs) begin
            acc_q.delete();
            m_err = 1'b0;
        end else begin
            e   = model_out(cyc);
            acc = st && !e[17];
            if (st && !acc) m_err = 1'b1;
            else if (clr)   m_err = 1'b0;
            if (acc) acc_q.push_back(cyc);
        end
        if (sel) begin
            s_if.in_start = st; s_if.clear_err = clr; rst_s = rs;
        end else begin
            d_if.in_start = st; d_if.clear_err = clr; rst_d = rs;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        logic [63:0] e, g;
        do_reset();
        for (int r = 0; r < 20; r++) begin
            e = model_out(cyc); g = obs();
            checks++;
            if (g !== e) begin errors++; $display("[TB] FAIL reset r=%0d got=%h exp=%h", r, g, e); end
            if (r == 0) begin
                checks++;
                if (g !== 64'h0) begin errors++; $display("[TB] FAIL reset_zero got=%h exp=0", g); end
            end
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_single();
        logic [63:0] e, g;
        do_reset();
        for (int r = 0; r < 130; r++) begin
            e = model_out(cyc); g = obs();
            checks++;
            if (g !== e) begin errors++; $display("[TB] FAIL single r=%0d got=%h exp=%h", r, g, e); end
            if (r == 18 || r == 90) begin
                checks++;
                if ((r == 18 ? d_if.stage_start[0] : d_if.out_start) !== 1'b1) begin
                    errors++; $display("[TB] FAIL single_start r=%0d got=0 exp=1", r);
                end
            end
            if (r == 121) begin
                checks++;
                if (d_if.frame_done !== 1'b1) begin errors++; $display("[TB] FAIL single_done got=%b exp=1", d_if.frame_done); end
            end
            if (r == 91) begin
                checks++;
                if (d_if.frames_in_flight !== 3'd0) begin errors++; $display("[TB] FAIL single_fif got=%0d exp=0", d_if.frames_in_flight); end
            end
            drive(r == 10, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e, g;
        do_reset();
        for (int r = 0; r < 190; r++) begin
            e = model_out(cyc); g = obs();
            checks++;
            if (g !== e) begin errors++; $display("[TB] FAIL b2b r=%0d got=%h exp=%h", r, g, e); end
            if (r == 80) begin
                checks++;
                if (d_if.frames_in_flight !== 3'd3) begin errors++; $display("[TB] FAIL b2b_peak got=%0d exp=3", d_if.frames_in_flight); end
            end
            if (r == 154) begin
                checks++;
                if (d_if.out_start !== 1'b1 || d_if.err_overlap !== 1'b0) begin
                    errors++; $display("[TB] FAIL b2b_third got=%b/%b exp=1/0", d_if.out_start, d_if.err_overlap);
                end
            end
            drive(r == 10 || r == 42 || r == 74, 1'b0, 1'b0);
        end
    endtask

    task automatic test_overlap();
        logic [63:0] e, g;
        do_reset();
        for (int r = 0; r < 160; r++) begin
            e = model_out(cyc); g = obs();
            checks++;
            if (g !== e) begin errors++; $display("[TB] FAIL overlap r=%0d got=%h exp=%h", r, g, e); end
            if (r == 16 || r == 41) begin
                checks++;
                if (d_if.err_overlap !== 1'b1 || (r == 41 && d_if.in_beat_idx !== 5'd31)) begin
                    errors++; $display("[TB] FAIL overlap_err r=%0d got=%b/%0d exp=1/31", r, d_if.err_overlap, d_if.in_beat_idx);
                end
            end
            if (r == 95) begin
                checks++;
                if (d_if.out_start !== 1'b0) begin errors++; $display("[TB] FAIL overlap_phantom got=1 exp=0"); end
            end
            drive(r == 10 || r == 15, 1'b0, 1'b0);
        end
    endtask

    task automatic test_clear_err();
        logic [63:0] e, g;
        do_reset();
        for (int r = 0; r < 130; r++) begin
            e = model_out(cyc); g = obs();
            checks++;
            if (g !== e) begin errors++; $display("[TB] FAIL clear r=%0d got=%h exp=%h", r, g, e); end
            if (r == 51 || r == 61) begin
                checks++;
                if (d_if.err_overlap !== (r == 51)) begin
                    errors++; $display("[TB] FAIL clear_err r=%0d got=%b exp=%b", r, d_if.err_overlap, r == 51);
                end
            end
            drive(r == 30 || r == 50, r == 50 || r == 60, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] e, g;
        do_reset();
        for (int r = 0; r < 170; r++) begin
            e = model_out(cyc); g = obs();
            checks++;
            if (g !== e) begin errors++; $display("[TB] FAIL rstmid r=%0d got=%h exp=%h", r, g, e); end
            if (r == 41) begin
                checks++;
                if (g !== 64'h0) begin errors++; $display("[TB] FAIL rstmid_zero got=%h exp=0", g); end
            end
            if (r == 90 || r == 125) begin
                checks++;
                if (d_if.out_start !== (r == 125)) begin
                    errors++; $display("[TB] FAIL rstmid_out r=%0d got=%b exp=%b", r, d_if.out_start, r == 125);
                end
            end
            drive(r == 10 || r == 45, 1'b0, r == 40);
        end
    endtask

    task automatic test_random();
        logic [63:0] e, g;
        do_reset();
        for (int r = 0; r < 1500; r++) begin
            e = model_out(cyc); g = obs();
            checks++;
            if (g !== e) begin errors++; $display("[TB] FAIL random r=%0d got=%h exp=%h", r, g, e); end
            drive($urandom_range(0, 14) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 499) == 0);
        end
    endtask

    task automatic test_config_sweep();
        logic [63:0] e, g;
        d_if.in_start = 1'b0; d_if.clear_err = 1'b0;
        sel = 1'b1; m_beats = 8; m_lat = 1; m_nst = 6;
        do_reset();
        for (int r = 0; r < 400; r++) begin
            e = model_out(cyc); g = obs();
            checks++;
            if (g !== e) begin errors++; $display("[TB] FAIL sweep r=%0d got=%h exp=%h", r, g, e); end
            if (r >= 1 && r <= 6) begin
                checks++;
                if (s_if.stage_start !== 6'(1 << (r - 1))) begin
                    errors++; $display("[TB] FAIL sweep_stage r=%0d got=%b exp=%b", r, s_if.stage_start, 6'(1 << (r - 1)));
                end
            end
            if (r == 13 || r == 14) begin
                checks++;
                if ((r == 13 ? s_if.frame_done : s_if.out_start) !== 1'b1) begin
                    errors++; $display("[TB] FAIL sweep_edge r=%0d got=0 exp=1", r);
                end
            end
            if (r < 40) drive(r == 0 || r == 8, 1'b0, 1'b0);
            else        drive($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
        end
    endtask

    initial begin
        d_if.in_start = 1'b0; d_if.clear_err = 1'b0;
        s_if.in_start = 1'b0; s_if.clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overlap();
        test_clear_err();
        test_reset_mid();
        test_random();
        test_config_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_stage_sequencer.md
Name: ntt_stage_sequencer

Overview:
- Control-plane sequencer for the streaming N-point, P-lane NTT pipeline.
- Accepts one frame-start pulse per N/P-beat input frame and admits or rejects it against the ingest window.
- Generates the start pulse for each downstream stage (butterfly + permutation) at its fixed pipeline offset.
- Tracks frames in flight, output beat position, per-frame completion and a sticky overlap error.

Parameters:
- N, 1024, transform size (points per frame).
- P, 32, lanes per cycle (inData_0..inData_P-1 width of the datapath).
- NUM_STAGES, 10, number of pipelined stages; equals log2(N).
- STAGE_LAT, 8, clock cycles from one stage's start to the next stage's start; must be 1 or more.

Derived constants:
- BEATS = N/P.
- BW = $clog2(BEATS).
- TOT_LAT = NUM_STAGES*STAGE_LAT.
- FW = $clog2(TOT_LAT/BEATS + 3).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_start  in  1  one-cycle pulse, co-timed with beat 0 of an input frame.
- clear_err  in  1  clears err_overlap.
- stage_start  out  NUM_STAGES  bit s pulses when stage s must see beat 0.
- out_start  out  1  equals stage_start[NUM_STAGES-1]; beat 0 of the result frame.
- in_busy  out  1  ingest window of an accepted frame still open.
- in_beat_idx  out  BW  index of the current ingest beat.
- out_beat_idx  out  BW  index of the current egress beat.
- frame_done  out  1  pulses on the last egress beat.
- frames_in_flight  out  FW  number of accepted frames whose out_start has not yet fired.
- err_overlap  out  1  sticky; an in_start was rejected.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: every output and every internal register is 0, including the delay line, both beat counters, the frame counter and the error flag.
- Reset mid-operation discards all frames in flight. No out_start or frame_done fires for them afterwards.
- Acceptance: in_start is accepted iff in_busy=0 in that cycle.
- Accepted in_start at cycle t:
  - in_busy=1 for cycles t+1..t+BEATS-1.
  - in_beat_idx=k at cycle t+k for k=1..BEATS-1; 0 otherwise.
- Back-to-back frames: an in_start at t+BEATS is accepted, because in_busy is 0 by then.
- Rejection: in_start with in_busy=1 is ignored. It does not enter the delay line and does not restart the counter. err_overlap=1 from the next cycle.
- Error clear: err_overlap clears at the edge after clear_err=1. If clear_err and a rejection occur in the same cycle, the error is set (set wins).
- Start chain: a shift-register delay line of TOT_LAT bits fed by accepted in_start.
  - stage_start[s] pulses at cycle t+(s+1)*STAGE_LAT, exactly one cycle wide.
  - out_start pulses at t+TOT_LAT.
  - Several frames coexist in the delay line with no interaction.
- Egress: out_start at cycle u gives out_beat_idx=k at u+k for k=1..BEATS-1 (0 otherwise), and frame_done pulses at u+BEATS-1.
  - Egress spacing is inherited from ingest spacing, so egress windows never overlap.
- frames_in_flight update:
  - +1 at the edge after an accepted in_start.
  - -1 at the edge after out_start.
  - Unchanged when both occur in the same cycle.
  - Never wraps; it is bounded by construction. An assertion checks no overflow and no underflow.
- Arithmetic: both beat counters wrap BEATS-1 -> 0 and are modular in BW bits. No other arithmetic.
- Purely sequencing: the block does not touch data words. Permutation and butterfly stages consume stage_start as their in_start.

Decomposition:
- Shared package ntt_cfg_pkg holds:
  - N, P, BEATS, BW, NUM_STAGES, STAGE_LAT, TOT_LAT.
  - typedef beat_idx_t (logic [BW-1:0]).
  - typedef stage_mask_t (logic [NUM_STAGES-1:0]).
- Sub-module ntt_beat_window:
  - Contents: beat counter plus busy flag.
  - Ports: start pulse in; busy, beat_idx and last-beat out.
  - Instantiated twice: once for ingest (qualified start) and once for egress (out_start).
- The delay line, acceptance logic, frame counter and error flag stay in the top module.

Test Plan:
- Single frame, in_start at cycle 10 with defaults:
  - stage_start[0] at 18, stage_start[9] and out_start at 90.
  - in_busy over 11..41.
  - frame_done at 121.
  - frames_in_flight 1 over 11..90, back to 0 at 91.
- Three back-to-back frames, in_start at 10, 42, 74:
  - all accepted; out_start at 90, 122, 154.
  - frames_in_flight peaks at 3 (cycles 75..90).
  - err_overlap stays 0.
- Overlap: in_start at 10 and 15:
  - second pulse is rejected; only one out_start, at 90.
  - err_overlap=1 from 16.
  - in_beat_idx reaches 31 at 41 without restarting.
- Clear and error in the same cycle: in_start at 50 (in_busy=1) with clear_err=1 at 50 -> err_overlap remains 1.
  - clear_err alone at 60 -> err_overlap=0 from 61.
- Reset mid-flight: in_start at 10, rst at 40:
  - all outputs are 0 from 41.
  - no out_start at 90.
  - a new in_start at 45 is accepted, giving out_start at 125.
- Config sweep N=64, P=8, NUM_STAGES=6, STAGE_LAT=1:
  - in_start at 0 -> stage_start[s] at s+1, out_start at 6.
  - frame_done at 13.
  - back-to-back in_start at 8 is accepted.
